// File: rtl/mvm_pkg.sv
// Shared constants, index-width helper and FSM state type for the MVM feeder.
package mvm_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned COLS  = 128;
    localparam int unsigned ROWS  = 128;
    localparam int unsigned ACC_W = 28;

    // Counter width for n entries; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CIDX_W = idx_w(COLS);
    localparam int unsigned RIDX_W = idx_w(ROWS);

    typedef enum logic [1:0] {
        StIdle,
        StLoadVec,
        StStream,
        StDone
    } state_e;

endpackage

// File: rtl/mvm_vec_buf.sv
// Vector buffer: COLS x DW storage, one synchronous write port, one async read port.
// Contents are deliberately not reset; every job reloads the whole vector.
module mvm_vec_buf
    import mvm_pkg::*;
#(
    parameter int unsigned DW   = mvm_pkg::DW,
    parameter int unsigned COLS = mvm_pkg::COLS,
    parameter int unsigned AW   = idx_w(COLS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [COLS];

    // Write port: store one vector element per accepted transfer.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mvm_feeder.sv
// Matrix-vector feeder: loads a vector, then streams signed element products of each
// matrix row against it to a downstream accumulator with restart/last markers.
module mvm_feeder
    import mvm_pkg::*;
#(
    parameter int unsigned DW   = mvm_pkg::DW,
    parameter int unsigned COLS = mvm_pkg::COLS,
    parameter int unsigned ROWS = mvm_pkg::ROWS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [DW-1:0]    vec_data,
    output logic             vec_ready,
    input  logic             mat_valid,
    input  logic [DW-1:0]    mat_data,
    output logic             mat_ready,
    output logic [ACC_W-1:0] prod_o,
    output logic             aac_o,
    output logic             last_o,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = idx_w(COLS);
    localparam int unsigned RW = idx_w(ROWS);
    localparam int unsigned PW = 2 * DW;
    localparam logic [CW-1:0] CLast = CW'(COLS - 1);
    localparam logic [RW-1:0] RLast = RW'(ROWS - 1);

    state_e state_q, state_d;
    logic [CW-1:0] vidx_q, vidx_d;
    logic [CW-1:0] cidx_q, cidx_d;
    logic [RW-1:0] ridx_q, ridx_d;
    logic [ACC_W-1:0] prod_q, prod_d;
    logic aac_q, aac_d;
    logic last_q, last_d;

    logic vec_hs, mat_hs;
    logic [DW-1:0] buf_rdata;
    logic signed [PW-1:0] prod_full;

    mvm_vec_buf #(
        .DW   (DW),
        .COLS (COLS),
        .AW   (CW)
    ) u_vec_buf (
        .clk_i   (clk),
        .we_i    (vec_hs),
        .waddr_i (vidx_q),
        .wdata_i (vec_data),
        .raddr_i (cidx_q),
        .rdata_o (buf_rdata)
    );

    assign vec_ready = (state_q == StLoadVec);
    assign mat_ready = (state_q == StStream);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign vec_hs    = vec_valid & vec_ready;
    assign mat_hs    = mat_valid & mat_ready;

    // Full-precision signed product; operands sign-extended before multiplying.
    assign prod_full = PW'($signed(mat_data)) * PW'($signed(buf_rdata));

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        vidx_d  = vidx_q;
        cidx_d  = cidx_q;
        ridx_d  = ridx_q;
        prod_d  = '0;
        aac_d   = 1'b0;
        last_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoadVec;
                    vidx_d  = '0;
                    cidx_d  = '0;
                    ridx_d  = '0;
                end
            end
            StLoadVec: begin
                if (vec_hs) begin
                    if (vidx_q == CLast) begin
                        vidx_d  = '0;
                        state_d = StStream;
                    end else begin
                        vidx_d = vidx_q + CW'(1);
                    end
                end
            end
            StStream: begin
                // A bubble feeds zero with accumulate held so the running sum survives.
                aac_d = 1'b1;
                if (mat_hs) begin
                    prod_d = ACC_W'(prod_full);
                    aac_d  = (cidx_q != '0);
                    last_d = (cidx_q == CLast);
                    if (cidx_q == CLast) begin
                        cidx_d = '0;
                        if (ridx_q == RLast) begin
                            state_d = StDone;
                        end else begin
                            ridx_d = ridx_q + RW'(1);
                        end
                    end else begin
                        cidx_d = cidx_q + CW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counters and product register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            vidx_q  <= '0;
            cidx_q  <= '0;
            ridx_q  <= '0;
            prod_q  <= '0;
            aac_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vidx_q  <= vidx_d;
            cidx_q  <= cidx_d;
            ridx_q  <= ridx_d;
            prod_q  <= prod_d;
            aac_q   <= aac_d;
            last_q  <= last_d;
        end
    end

    assign prod_o = prod_q;
    assign aac_o  = aac_q;
    assign last_o = last_q;

endmodule

// File: doc/mvm_feeder.md
MVM_FEEDER -- requirements
Module: mvm_feeder

Interface
REQ-001 The module SHALL have parameter DW, default 8: signed width of matrix and vector elements.
REQ-002 The module SHALL have parameter COLS, default 128: vector length, i.e. matrix columns.
REQ-003 The module SHALL have parameter ROWS, default 128: matrix rows per job.
REQ-004 The module SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-005 The module SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 The module SHALL have port start  in  1: one-cycle job launch pulse.
REQ-007 The module SHALL have ports vec_valid  in  1, vec_data  in  DW, vec_ready  out  1: vector element handshake.
REQ-008 The module SHALL have ports mat_valid  in  1, mat_data  in  DW, mat_ready  out  1: row-major matrix element handshake.
REQ-009 The module SHALL have port prod_o  out  28: signed product, sign-extended, to the accumulator data input.
REQ-010 The module SHALL have port aac_o  out  1: accumulate-enable to the accumulator, 0 = restart sum.
REQ-011 The module SHALL have ports last_o  out  1, busy  out  1, done  out  1: last term of row, job active, job-complete pulse.

Function
REQ-012 The FSM SHALL use states IDLE, LOAD_VEC, STREAM, DONE.
REQ-013 IDLE: start=1 SHALL go to LOAD_VEC and clear all counters; start in other states SHALL be ignored.
REQ-014 LOAD_VEC: vec_ready=1; each vec_valid&vec_ready SHALL write vec_data to buffer[vidx] and increment vidx; the COLS-th transfer SHALL go to STREAM.
REQ-015 STREAM: mat_ready=1; each mat_valid&mat_ready SHALL register prod_o = sext28(mat_data * buffer[cidx]), signed DW x DW to 2*DW bits.
REQ-016 Latency SHALL be 1 cycle: prod_o, aac_o and last_o are valid the cycle after the accepted handshake.
REQ-017 For an accepted term, aac_o SHALL be 0 when cidx==0 and 1 otherwise.
REQ-018 For an accepted term, last_o SHALL be 1 when cidx==COLS-1, else 0.
REQ-019 cidx SHALL wrap from COLS-1 to 0 and increment ridx.
REQ-020 A bubble cycle (STREAM, mat_valid=0) SHALL drive prod_o=0, aac_o=1, last_o=0 the next cycle so the running sum is preserved.
REQ-021 Outside STREAM, the registered outputs SHALL be prod_o=0, aac_o=0, last_o=0.
REQ-022 After the accepted term with ridx==ROWS-1 and cidx==COLS-1, the FSM SHALL enter DONE; done=1 for exactly one cycle; the FSM then returns to IDLE.
REQ-023 busy SHALL be 1 in LOAD_VEC, STREAM and DONE, and 0 in IDLE.
REQ-024 The worst-case row sum COLS*2^(2*DW-2) SHALL fit in 28 signed bits; no saturation SHALL be applied.

Reset
REQ-025 Reset=1 at any cycle, including mid-job, SHALL force IDLE and clear vidx, cidx and ridx.
REQ-026 Reset SHALL drive prod_o=0, aac_o=0, last_o=0, busy=0, done=0, vec_ready=0 and mat_ready=0 on the next edge.
REQ-027 Buffer contents SHALL NOT be reset; a new job SHALL always reload the full vector.

Structure
REQ-028 Package mvm_pkg SHALL hold DW, COLS, ROWS, ACC_W=28, the state enum, and index widths clog2(COLS) and clog2(ROWS).
REQ-029 The vector buffer SHALL be sub-module mvm_vec_buf: COLS x DW, one write port, one async read port.
REQ-030 The FSM, counters and product register SHALL reside in mvm_feeder.

Verification
REQ-031 Bench SHALL cover: COLS=4, ROWS=2, vector {1,2,3,4}, matrix rows {1,1,1,1},{-1,0,2,-128} -> prod_o stream 1,2,3,4 / -1,0,6,-512 with aac_o 0,1,1,1 per row, last_o on 4th and 8th terms, done one cycle after 8th term.
REQ-032 Bench SHALL cover: extremes -128*-128 -> prod_o=16384; -128*127 -> prod_o=0xFFFC080 (28-bit sign-extended).
REQ-033 Bench SHALL cover: mat_valid deasserted 3 cycles mid-row -> three prod_o=0, aac_o=1 cycles; a downstream accumulator row sum equals the gap-free case.
REQ-034 Bench SHALL cover: reset asserted during STREAM at ridx=1 -> next cycle IDLE, busy=0, all outputs 0; a new start reloads the vector and yields correct sums.
REQ-035 Bench SHALL cover: start pulsed during LOAD_VEC and STREAM -> no effect on counters or output stream.
REQ-036 Bench SHALL cover: defaults COLS=ROWS=128 with all elements -128 -> every row sum, checked through the accumulator, equals 2097152 with no overflow.
